// File: rtl/rot_seq_pkg.sv
// Shared types and constants for the rotate sequencer.
// Holds the FSM state enum, mode encodings, default sizes and select decode.
package rot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam logic [1:0] MODE_ROR  = 2'b00;
  localparam logic [1:0] MODE_ROL  = 2'b01;
  localparam logic [1:0] MODE_ASR  = 2'b10;
  localparam logic [1:0] MODE_ROL2 = 2'b11;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_DIV_W = 24;

  // Returns {ro_right, as_right} for a mode.
  function automatic logic [1:0] mode_sel(input logic [1:0] mode);
    logic [1:0] sel;
    sel = 2'b00;
    unique case (mode)
      MODE_ROR:  sel = 2'b10;
      MODE_ASR:  sel = 2'b11;
      MODE_ROL,
      MODE_ROL2: sel = 2'b00;
      default:   sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Reloadable down-counter setting the spacing between shift steps.
// Ports: clock, reset, load, enable, reload[DIV_W], zero (count==0 while enabled).
module step_divider
  import rot_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] reload,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_zero;

  assign at_zero = (cnt_q == '0);
  assign zero    = enable & at_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = reload;
    end else if (enable) begin
      // Reload on zero so steps repeat every reload+1 cycles.
      cnt_d = at_zero ? reload : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Sequences an 8-bit rotate/shift register: one load then count timed steps.
// Ports: clock, reset, start, abort, mode, count, pattern, tick_div in;
//   data_out, load_n, ro_right, as_right, reg_step, busy, done out.
// Option: ROTSEQ_CONTINUOUS_EN makes count=0 step forever until abort/reset.
module rotate_sequencer
  import rot_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] pattern,
  input  logic [DIV_W-1:0] tick_div,
  output logic [WIDTH-1:0] data_out,
  output logic             load_n,
  output logic             ro_right,
  output logic             as_right,
  output logic             reg_step,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [DIV_W-1:0] tick_q, tick_d;

  logic div_load;
  logic div_en;
  logic div_zero;
  logic run_forever;
  logic [1:0] sel;

`ifdef ROTSEQ_CONTINUOUS_EN
  assign run_forever = (count_q == '0);
`else
  assign run_forever = 1'b0;
`endif

  assign sel = mode_sel(mode_q);

  step_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .load  (div_load),
    .enable(div_en),
    .reload(tick_q),
    .zero  (div_zero)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    steps_d  = steps_q;
    pat_d    = pat_q;
    tick_d   = tick_q;
    div_load = 1'b0;
    div_en   = 1'b0;
    data_out = '0;
    load_n   = 1'b1;
    ro_right = 1'b0;
    as_right = 1'b0;
    reg_step = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          count_d = count;
          pat_d   = pattern;
          tick_d  = tick_div;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        load_n   = 1'b0;
        data_out = pat_q;
        ro_right = sel[1];
        as_right = sel[0];
        if (abort) begin
          state_d = IDLE;
        end else begin
          reg_step = 1'b1;
          div_load = 1'b1;
          steps_d  = count_q;
          if (count_q == '0 && !run_forever) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy     = 1'b1;
        data_out = pat_q;
        ro_right = sel[1];
        as_right = sel[0];
        if (abort) begin
          state_d = IDLE;
        end else begin
          div_en = 1'b1;
          if (div_zero) begin
            reg_step = 1'b1;
            if (!run_forever) begin
              // Saturating decrement: never wraps below zero.
              if (steps_q != '0) begin
                steps_d = steps_q - CNT_W'(1);
              end
              if (steps_q <= CNT_W'(1)) begin
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      count_q <= '0;
      steps_q <= '0;
      pat_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      steps_q <= steps_d;
      pat_q   <= pat_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Controller that sequences an 8-bit rotating/shift register datapath (load, rotate right/left, arithmetic shift right).
- On a start request it performs one parallel load followed by a programmed number of shift steps at a programmable rate.
- The register's clock enable and mux selects (load_n, ro_right, as_right) are driven from this block.
- Sits between the switch/key user interface and the register; reports busy/done to the top level.

Parameters:
- WIDTH, 8, data width of pattern/data_out.
- CNT_W, 4, width of step count.
- DIV_W, 24, width of the step-rate divider.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled in IDLE only.
- abort  in  1  stop sequence; return to IDLE next cycle.
- mode  in  2  00 rotate right, 01 rotate left, 10 arithmetic shift right, 11 rotate left.
- count  in  CNT_W  number of shift steps after the load.
- pattern  in  WIDTH  load value.
- tick_div  in  DIV_W  step spacing minus 1, in clock cycles.
- data_out  out  WIDTH  to register DATA_IN.
- load_n  out  1  0 = load, 1 = shift.
- ro_right  out  1  1 = shift right, 0 = shift left.
- as_right  out  1  1 = MSB keeps its value on a right shift, 0 = rotate.
- reg_step  out  1  one-cycle clock enable to the register.
- busy  out  1  high from the LOAD cycle through the last step.
- done  out  1  one-cycle pulse after the final step.

Behaviour:
- Reset values: state IDLE; all outputs 0 except load_n = 1; internal counters 0.
- Reset has priority over abort and start.
- IDLE:
  - start = 1 captures mode, count, pattern and tick_div into registers; next state LOAD.
  - Inputs are ignored in every other state.
- LOAD (1 cycle):
  - reg_step = 1, load_n = 0, data_out = captured pattern, busy = 1.
  - Captured count = 0: next state DONE.
  - Otherwise: next state RUN, div_cnt = tick_div, steps_left = count.
- RUN:
  - div_cnt decrements each cycle.
  - In the cycle div_cnt = 0: reg_step = 1, load_n = 1, steps_left decrements, div_cnt reloads tick_div.
  - That step is the last (steps_left was 1): next state DONE.
- Timing:
  - The first step is tick_div+1 cycles after the LOAD cycle; later steps are tick_div+1 cycles apart.
  - tick_div = 0 gives one step per cycle.
- DONE (1 cycle): done = 1, busy = 0; next state IDLE. A start in DONE is ignored.
- Select outputs from the captured mode, held constant while busy:
  - mode 00: ro_right = 1, as_right = 0.
  - mode 10: ro_right = 1, as_right = 1.
  - mode 01 or 11: ro_right = 0, as_right = 0.
  - All selects = 0 in IDLE.
- abort in LOAD or RUN:
  - No reg_step that cycle; next state IDLE; done is not pulsed; busy drops the next cycle.
- Latency from start to done: 2 cycles for count = 0; (count·(tick_div+1)) + 2 cycles otherwise.
- Arithmetic:
  - div_cnt and steps_left are unsigned and never wrap below 0.
  - The maximum count is 2^CNT_W−1.

Optional Feature:
- Macro ROTSEQ_CONTINUOUS_EN.
- Defined: count = 0 means run forever. The block enters RUN, steps indefinitely (steps_left is not decremented) and leaves only on abort or reset; done is never pulsed for such a run.
- Undefined: count = 0 goes LOAD→DONE as specified above.

Decomposition:
- Shared package rot_seq_pkg contains:
  - State enum: IDLE, LOAD, RUN, DONE.
  - Mode constants: MODE_ROR = 2'b00, MODE_ROL = 2'b01, MODE_ASR = 2'b10, MODE_ROL2 = 2'b11.
  - Default parameter constants.
- One sub-module, step_divider: a reloadable down-counter with load, enable and a zero-pulse output, DIV_W wide.

Test Plan:
- Rotate right: pattern 8'h81, mode 00, count 3, tick_div 0 → 3 reg_step pulses on consecutive cycles; model register ends at 8'h30; done asserts 5 cycles after start.
- Arithmetic shift right: pattern 8'h80, mode 10, count 2, tick_div 4 → steps 5 cycles apart; register ends at 8'hE0; as_right = 1 throughout busy.
- Rotate left: pattern 8'h81, mode 01, count 1 → register 8'h03; ro_right = 0.
- count 0: with the macro undefined → load only, done 2 cycles after start. With ROTSEQ_CONTINUOUS_EN → continuous steps, done stays 0 until abort.
- abort after the second of 5 steps (tick_div 2) → no further reg_step, no done, IDLE next cycle; a start 2 cycles later is accepted.
- Edge cases:
  - start while busy → ignored; captured values unchanged.
  - reset asserted mid-RUN → all outputs at their reset values next cycle.
